// File: rtl/helper_axis_pkg.sv
// Shared types and constants for the AXI-Stream counting-sequence checker.
// Holds the FSM state enum, ready-mode selectors and the 16-bit LFSR tap mask.
package helper_axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int READY_ALWAYS = 0;
    localparam int READY_LFSR   = 1;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_feedback(input logic [15:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/helper_lfsr16.sv
// 16-bit Fibonacci LFSR; shifts left and inserts the feedback bit at bit 0.
// Loads the seed on reset and only steps while advance is high.
module helper_lfsr16
    import helper_axis_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= seed;
        end else if (advance) begin
            r_state <= {r_state[14:0], lfsr_feedback(r_state)};
        end
    end

    assign state = r_state;

endmodule

// File: rtl/helper_axis_checker.sv
// Sink that accepts an AXI-Stream source and checks it emits 0,1,2,... modulo 2^DATA_WIDTH,
// counting transfers and mismatches and capturing the first mismatch of each run.
module helper_axis_checker
    import helper_axis_pkg::*;
#(
    parameter int          DATA_WIDTH     = 10,
    parameter int          READY_MODE     = READY_ALWAYS,
    parameter int          EXPECTED_COUNT = 0,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  input_valid,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  input_ready,
    output logic [31:0]           transfer_count,
    output logic [15:0]           error_count,
    output logic                  first_error_valid,
    output logic [31:0]           first_error_index,
    output logic [DATA_WIDTH-1:0] first_error_expected,
    output logic [DATA_WIDTH-1:0] first_error_received,
    output logic                  done,
    output state_t                debug_state
);

    state_t                r_state;
    logic                  r_ready;
    logic                  r_done;
    logic [31:0]           r_transfer_count;
    logic [15:0]           r_error_count;
    logic                  r_first_valid;
    logic [31:0]           r_first_index;
    logic [DATA_WIDTH-1:0] r_first_expected;
    logic [DATA_WIDTH-1:0] r_first_received;
    logic [DATA_WIDTH-1:0] r_expected;

    logic                  w_xfer;
    logic                  w_mismatch;
    logic                  w_last;
    logic                  w_lfsr_advance;
    logic [15:0]           w_lfsr_state;
    logic                  w_ready_entry;
    logic                  w_ready_next;
    logic [31:0]           w_count_inc;

    helper_lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (w_lfsr_advance),
        .seed    (LFSR_SEED),
        .state   (w_lfsr_state)
    );

    // Handshake: a beat is accepted on a rising edge where input_valid and input_ready
    // are both high; input_ready is registered and never looks at input_valid.
    assign w_xfer         = (r_state == ST_RUN) && input_valid && r_ready;
    assign w_mismatch     = w_xfer && (input_data != r_expected);
    assign w_count_inc    = r_transfer_count + 32'd1;
    assign w_last         = w_xfer && (EXPECTED_COUNT > 0) && (w_count_inc == 32'(EXPECTED_COUNT));
    assign w_lfsr_advance = (r_state == ST_RUN);

    // Ready for the coming cycle is the LFSR bit 0 as it will be after this cycle's step.
    assign w_ready_entry = (READY_MODE == READY_LFSR) ? w_lfsr_state[0] : 1'b1;
    assign w_ready_next  = (READY_MODE == READY_LFSR) ? lfsr_feedback(w_lfsr_state) : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_ready          <= 1'b0;
            r_done           <= 1'b0;
            r_transfer_count <= '0;
            r_error_count    <= '0;
            r_first_valid    <= 1'b0;
            r_first_index    <= '0;
            r_first_expected <= '0;
            r_first_received <= '0;
            r_expected       <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state          <= ST_RUN;
                        r_ready          <= w_ready_entry;
                        r_done           <= 1'b0;
                        r_transfer_count <= '0;
                        r_error_count    <= '0;
                        r_first_valid    <= 1'b0;
                        r_first_index    <= '0;
                        r_first_expected <= '0;
                        r_first_received <= '0;
                        r_expected       <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_xfer) begin
                        r_transfer_count <= w_count_inc;
                        r_expected       <= r_expected + DATA_WIDTH'(1);
                    end
                    if (w_mismatch) begin
                        if (r_error_count != 16'hFFFF) begin
                            r_error_count <= r_error_count + 16'd1;
                        end
                        if (!r_first_valid) begin
                            r_first_valid    <= 1'b1;
                            r_first_index    <= r_transfer_count;
                            r_first_expected <= r_expected;
                            r_first_received <= input_data;
                        end
                    end
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b0;
                    end else begin
                        r_ready <= w_ready_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign input_ready          = r_ready;
    assign transfer_count       = r_transfer_count;
    assign error_count          = r_error_count;
    assign first_error_valid    = r_first_valid;
    assign first_error_index    = r_first_index;
    assign first_error_expected = r_first_expected;
    assign first_error_received = r_first_received;
    assign done                 = r_done;
    assign debug_state          = r_state;

endmodule

// File: doc/helper_axis_checker.md
HELPER_AXIS_CHECKER -- requirements
Module: helper_axis_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 10, width of the checked data bus.
REQ-002 Parameter READY_MODE, default 0; 0 = ready always high in RUN, 1 = pseudo-random ready stalls.
REQ-003 Parameter EXPECTED_COUNT, default 0; number of transfers to accept before DONE; 0 = unbounded.
REQ-004 Parameter LFSR_SEED, default 16'hACE1, non-zero seed for the ready pattern.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse; begins or restarts a check run.
REQ-008 input_valid  input  1  AXIS valid from the source under test.
REQ-009 input_data  input  DATA_WIDTH  AXIS data from the source under test.
REQ-010 input_ready  output  1  AXIS ready to the source.
REQ-011 transfer_count  output  32  accepted transfers in the current run.
REQ-012 error_count  output  16  mismatching transfers, saturating.
REQ-013 first_error_valid  output  1  high once any mismatch has been captured.
REQ-014 first_error_index  output  32  transfer_count value at the first mismatch.
REQ-015 first_error_expected / first_error_received  output  DATA_WIDTH each  values at the first mismatch.
REQ-016 done  output  1  high in DONE state.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DONE.
REQ-018 IDLE -> RUN on start; RUN -> DONE on the transfer that makes transfer_count equal EXPECTED_COUNT (EXPECTED_COUNT > 0); DONE -> RUN on start.
REQ-019 start in RUN SHALL be ignored.
REQ-020 Entering RUN SHALL clear transfer_count, error_count, first_error_* and set the expected value to 0.
REQ-021 A transfer SHALL occur in a cycle where input_valid and input_ready are both high.
REQ-022 input_ready SHALL be a registered output, low in IDLE and DONE, independent of input_valid.
REQ-023 In RUN with READY_MODE=0 input_ready SHALL be high from the first RUN cycle, with no idle cycle.
REQ-024 In RUN with READY_MODE=1 input_ready SHALL equal bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11) advanced every RUN cycle.
REQ-025 On each transfer, input_data SHALL be compared to the expected value; expected SHALL then increment modulo 2^DATA_WIDTH (2^DATA_WIDTH-1 wraps to 0).
REQ-026 On a mismatch, error_count SHALL increment and hold at 16'hFFFF without wrapping.
REQ-027 On the first mismatch of a run, first_error_* SHALL be captured and held until the next RUN entry.
REQ-028 transfer_count SHALL increment on every transfer; outputs SHALL update the cycle after the transfer.
REQ-029 With EXPECTED_COUNT=0, the block SHALL never enter DONE.
REQ-030 In DONE, input_ready SHALL be low in the cycle after the final transfer, and counters SHALL hold.

Reset
REQ-031 rst SHALL force IDLE, input_ready=0, done=0, all counters and first_error_* to 0, and the LFSR to LFSR_SEED.
REQ-032 rst SHALL take priority over start and over a simultaneous transfer; a transfer in the reset cycle is discarded.
REQ-033 rst mid-RUN SHALL abandon the run; a new run requires start.

Structure
REQ-034 Package helper_axis_pkg SHALL hold the FSM state enum, the READY_MODE constants and the LFSR tap mask.
REQ-035 The LFSR SHALL be a sub-module helper_lfsr16 (clk, rst, advance, seed, state).

Verification
REQ-036 READY_MODE=0, EXPECTED_COUNT=8, source counts 0..7 continuously -> input_ready high for 8 cycles, transfer_count=8, error_count=0, done=1, input_ready low afterward.
REQ-037 DATA_WIDTH=4, EXPECTED_COUNT=20, counting source -> data wraps 15->0, error_count=0.
REQ-038 Source sends 0,1,2,9,4 -> error_count=1, first_error_index=3, expected=3, received=9.
REQ-039 READY_MODE=1, valid always high, EXPECTED_COUNT=100 -> ready shows stalls, done after exactly 100 transfers, error_count=0.
REQ-040 rst asserted after 5 transfers, then start -> counters at 0, expected restarts at 0, and a source restarted from 0 gives no errors.
REQ-041 start pulsed in RUN -> no counter clear; start in DONE -> counters cleared and a new run begins.
